// File: rtl/fmul_72bit_issue_arbiter_if.sv
// Handshake bundle joining two requesters, the shared 72-bit multiplier pipeline
// and the issue arbiter. slave = arbiter view, master = surrounding system view.
interface fmul_72bit_issue_arbiter_if #(
  parameter int CNT_W = 5
);
  logic             iREQ0_VALID;
  logic             oREQ0_BUSY;
  logic [71:0]      iREQ0_DATA_A;
  logic [71:0]      iREQ0_DATA_B;
  logic             iREQ1_VALID;
  logic             oREQ1_BUSY;
  logic [71:0]      iREQ1_DATA_A;
  logic [71:0]      iREQ1_DATA_B;
  logic             oPIPE_VALID;
  logic             iPIPE_BUSY;
  logic [71:0]      oPIPE_DATA_A;
  logic [71:0]      oPIPE_DATA_B;
  logic             iPIPE_RESULT_VALID;
  logic             oPIPE_RESULT_BUSY;
  logic [71:0]      iPIPE_RESULT_DATA;
  logic             oRES0_VALID;
  logic             iRES0_BUSY;
  logic [71:0]      oRES0_DATA;
  logic             oRES1_VALID;
  logic             iRES1_BUSY;
  logic [71:0]      oRES1_DATA;
  logic [CNT_W-1:0] oINFLIGHT;
  logic             oERR_ORPHAN;

  modport slave (
    input  iREQ0_VALID, iREQ0_DATA_A, iREQ0_DATA_B,
    input  iREQ1_VALID, iREQ1_DATA_A, iREQ1_DATA_B,
    input  iPIPE_BUSY, iPIPE_RESULT_VALID, iPIPE_RESULT_DATA,
    input  iRES0_BUSY, iRES1_BUSY,
    output oREQ0_BUSY, oREQ1_BUSY,
    output oPIPE_VALID, oPIPE_DATA_A, oPIPE_DATA_B, oPIPE_RESULT_BUSY,
    output oRES0_VALID, oRES0_DATA, oRES1_VALID, oRES1_DATA,
    output oINFLIGHT, oERR_ORPHAN
  );

  modport master (
    output iREQ0_VALID, iREQ0_DATA_A, iREQ0_DATA_B,
    output iREQ1_VALID, iREQ1_DATA_A, iREQ1_DATA_B,
    output iPIPE_BUSY, iPIPE_RESULT_VALID, iPIPE_RESULT_DATA,
    output iRES0_BUSY, iRES1_BUSY,
    input  oREQ0_BUSY, oREQ1_BUSY,
    input  oPIPE_VALID, oPIPE_DATA_A, oPIPE_DATA_B, oPIPE_RESULT_BUSY,
    input  oRES0_VALID, oRES0_DATA, oRES1_VALID, oRES1_DATA,
    input  oINFLIGHT, oERR_ORPHAN
  );
endinterface

// File: rtl/fmul_72bit_issue_arbiter.sv
// Round-robin issue arbiter for a shared in-order 72-bit FP multiplier: credit-limited
// issue stage, ordered tag FIFO of requester ids, and zero-latency result routing.
module fmul_72bit_issue_arbiter #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 5
) (
  input logic                       iCLOCK,
  input logic                       inRESET,
  input logic                       iRESET_SYNC,
  fmul_72bit_issue_arbiter_if.slave bus
);
  localparam int               PTR_W    = $clog2(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_INFLIGHT - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Pointers wrap at the FIFO depth, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  logic                    stage_v_q, stage_v_d;
  logic [71:0]             stage_a_q, stage_a_d;
  logic [71:0]             stage_b_q, stage_b_d;
  logic                    last_q, last_d;
  logic [MAX_INFLIGHT-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    orphan_q, orphan_d;

  logic grant_ok_s, gnt0_s, gnt1_s, push_s;
  logic empty_s, head_s, res_busy_s, pop_s;

  assign grant_ok_s = !bus.iPIPE_BUSY && (cnt_q < MAX_CNT);
  assign push_s     = gnt0_s || gnt1_s;
  assign empty_s    = (cnt_q == {CNT_W{1'b0}});
  assign head_s     = tag_q[rd_ptr_q];
  assign pop_s      = bus.iPIPE_RESULT_VALID && !empty_s && !res_busy_s;

  // Round-robin grant; last_q names the requester granted most recently
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (grant_ok_s) begin
      case ({bus.iREQ1_VALID, bus.iREQ0_VALID})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        2'b11: begin
          gnt0_s = last_q;
          gnt1_s = !last_q;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Result back-pressure follows whichever requester owns the oldest tag
  always_comb begin
    res_busy_s = 1'b0;
    if (empty_s) begin
      res_busy_s = 1'b0;
    end else if (head_s) begin
      res_busy_s = bus.iRES1_BUSY;
    end else begin
      res_busy_s = bus.iRES0_BUSY;
    end
  end

  // Next-state for issue stage, tag FIFO, credit count and orphan flag
  always_comb begin
    stage_v_d = stage_v_q;
    stage_a_d = stage_a_q;
    stage_b_d = stage_b_q;
    last_d    = last_q;
    tag_d     = tag_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    orphan_d  = orphan_q || (bus.iPIPE_RESULT_VALID && empty_s);
    if (!bus.iPIPE_BUSY) begin
      stage_v_d = push_s;
      if (gnt1_s) begin
        stage_a_d = bus.iREQ1_DATA_A;
        stage_b_d = bus.iREQ1_DATA_B;
      end else if (gnt0_s) begin
        stage_a_d = bus.iREQ0_DATA_A;
        stage_b_d = bus.iREQ0_DATA_B;
      end else begin
        stage_a_d = stage_a_q;
        stage_b_d = stage_b_q;
      end
    end else begin
      stage_v_d = stage_v_q;
    end
    if (push_s) begin
      tag_d[wr_ptr_q] = gnt1_s;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      last_d          = gnt1_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; the synchronous clear mirrors the asynchronous reset
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stage_v_q <= 1'b0;
      stage_a_q <= 72'd0;
      stage_b_q <= 72'd0;
      last_q    <= 1'b1;
      tag_q     <= {MAX_INFLIGHT{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      orphan_q  <= 1'b0;
    end else if (iRESET_SYNC) begin
      stage_v_q <= 1'b0;
      stage_a_q <= 72'd0;
      stage_b_q <= 72'd0;
      last_q    <= 1'b1;
      tag_q     <= {MAX_INFLIGHT{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      orphan_q  <= 1'b0;
    end else begin
      stage_v_q <= stage_v_d;
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      last_q    <= last_d;
      tag_q     <= tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      orphan_q  <= orphan_d;
    end
  end

  assign bus.oREQ0_BUSY        = !gnt0_s;
  assign bus.oREQ1_BUSY        = !gnt1_s;
  assign bus.oPIPE_VALID       = stage_v_q;
  assign bus.oPIPE_DATA_A      = stage_a_q;
  assign bus.oPIPE_DATA_B      = stage_b_q;
  assign bus.oPIPE_RESULT_BUSY = res_busy_s;
  assign bus.oRES0_VALID       = bus.iPIPE_RESULT_VALID && !empty_s && !head_s;
  assign bus.oRES1_VALID       = bus.iPIPE_RESULT_VALID && !empty_s && head_s;
  assign bus.oRES0_DATA        = bus.iPIPE_RESULT_DATA;
  assign bus.oRES1_DATA        = bus.iPIPE_RESULT_DATA;
  assign bus.oINFLIGHT         = cnt_q;
  assign bus.oERR_ORPHAN       = orphan_q;
endmodule

// File: tb/tb_fmul_72bit_issue_arbiter.sv
// Bench for the multiplier issue arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of the arbitration and tag-ordering rules.
module tb_fmul_72bit_issue_arbiter;
  localparam int MAXI = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic srst  = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fmul_72bit_issue_arbiter_if #(.CNT_W(5)) bus ();
  fmul_72bit_issue_arbiter #(.MAX_INFLIGHT(MAXI), .CNT_W(5)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst), .bus(bus)
  );

  // Reference model: outstanding requester ids in issue order, last winner, stage contents
  bit          m_tags[$];
  int          m_last;
  bit          m_sv;
  logic [71:0] m_sa, m_sb;
  bit          m_orph;
  bit          e_g0, e_g1, e_r0, e_r1, e_rb, e_pop, e_orph_ev, e_srst, e_pb;
  logic [71:0] e_a, e_b;

  function automatic logic [71:0] rnd72();
    logic [31:0] x, y, z;
    x = $urandom(); y = $urandom(); z = $urandom();
    return {x[7:0], y, z};
  endfunction

  task automatic model_reset();
    m_tags.delete(); m_last = 1; m_sv = 1'b0; m_sa = 72'd0; m_sb = 72'd0; m_orph = 1'b0;
  endtask

  task automatic model_eval();
    bit ok, empty, head;
    ok    = !bus.iPIPE_BUSY && (m_tags.size() < MAXI);
    e_g0  = ok && bus.iREQ0_VALID && (!bus.iREQ1_VALID || m_last == 1);
    e_g1  = ok && bus.iREQ1_VALID && (!bus.iREQ0_VALID || m_last == 0);
    empty = (m_tags.size() == 0);
    head  = empty ? 1'b0 : m_tags[0];
    e_r0  = bus.iPIPE_RESULT_VALID && !empty && (head == 1'b0);
    e_r1  = bus.iPIPE_RESULT_VALID && !empty && (head == 1'b1);
    e_rb  = empty ? 1'b0 : (head ? bus.iRES1_BUSY : bus.iRES0_BUSY);
    e_pop = bus.iPIPE_RESULT_VALID && !empty && !e_rb;
    e_orph_ev = bus.iPIPE_RESULT_VALID && empty;
    e_srst = srst;
    e_pb   = bus.iPIPE_BUSY;
    e_a    = e_g1 ? bus.iREQ1_DATA_A : bus.iREQ0_DATA_A;
    e_b    = e_g1 ? bus.iREQ1_DATA_B : bus.iREQ0_DATA_B;
  endtask

  task automatic model_clock();
    if (e_srst) begin
      model_reset();
    end else begin
      if (e_pop) void'(m_tags.pop_front());
      if (e_g0) begin m_tags.push_back(1'b0); m_last = 0; end
      if (e_g1) begin m_tags.push_back(1'b1); m_last = 1; end
      if (!e_pb) begin
        m_sv = e_g0 || e_g1;
        if (e_g0 || e_g1) begin m_sa = e_a; m_sb = e_b; end
      end
      m_orph = m_orph || e_orph_ev;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    bus.iREQ0_VALID = 1'b0; bus.iREQ0_DATA_A = 72'd0; bus.iREQ0_DATA_B = 72'd0;
    bus.iREQ1_VALID = 1'b0; bus.iREQ1_DATA_A = 72'd0; bus.iREQ1_DATA_B = 72'd0;
    bus.iPIPE_BUSY = 1'b0; bus.iPIPE_RESULT_VALID = 1'b0; bus.iPIPE_RESULT_DATA = 72'd0;
    bus.iRES0_BUSY = 1'b0; bus.iRES1_BUSY = 1'b0;
  endtask

  task automatic sync_clear();
    idle(); srst = 1'b1; tick(); srst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0; model_reset(); #3;
    checks++; if (bus.oPIPE_VALID !== 1'b0) begin failures++; $display("FAIL reset_pipe_valid got=%b exp=0", bus.oPIPE_VALID); end
    checks++; if (bus.oPIPE_DATA_A !== 72'd0 || bus.oPIPE_DATA_B !== 72'd0) begin failures++; $display("FAIL reset_pipe_data got=%h/%h exp=0", bus.oPIPE_DATA_A, bus.oPIPE_DATA_B); end
    checks++; if (bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", bus.oINFLIGHT); end
    checks++; if (bus.oRES0_VALID !== 1'b0 || bus.oRES1_VALID !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b%b exp=00", bus.oRES1_VALID, bus.oRES0_VALID); end
    checks++; if (bus.oERR_ORPHAN !== 1'b0) begin failures++; $display("FAIL reset_orphan got=%b exp=0", bus.oERR_ORPHAN); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [71:0] a, b;
    a = 72'h3FF_8000_0000_0000_00; b = rnd72();
    bus.iREQ0_VALID = 1'b1; bus.iREQ0_DATA_A = a; bus.iREQ0_DATA_B = b; #1;
    checks++; if (bus.oREQ0_BUSY !== 1'b0) begin failures++; $display("FAIL single_busy0 got=%b exp=0", bus.oREQ0_BUSY); end
    tick(); bus.iREQ0_VALID = 1'b0;
    checks++; if (bus.oPIPE_VALID !== 1'b1) begin failures++; $display("FAIL single_pipe_valid got=%b exp=1", bus.oPIPE_VALID); end
    checks++; if (bus.oPIPE_DATA_A !== a || bus.oPIPE_DATA_B !== b) begin failures++; $display("FAIL single_pipe_data got=%h/%h exp=%h/%h", bus.oPIPE_DATA_A, bus.oPIPE_DATA_B, a, b); end
    checks++; if (bus.oINFLIGHT !== 5'd1) begin failures++; $display("FAIL single_inflight got=%0d exp=1", bus.oINFLIGHT); end
    tick();
    bus.iPIPE_RESULT_VALID = 1'b1; bus.iPIPE_RESULT_DATA = 72'hABC; #1;
    checks++; if (bus.oRES0_VALID !== 1'b1 || bus.oRES1_VALID !== 1'b0) begin failures++; $display("FAIL single_route got=%b%b exp=01", bus.oRES1_VALID, bus.oRES0_VALID); end
    checks++; if (bus.oRES0_DATA !== 72'hABC) begin failures++; $display("FAIL single_res_data got=%h exp=abc", bus.oRES0_DATA); end
    tick(); bus.iPIPE_RESULT_VALID = 1'b0;
    checks++; if (bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL single_inflight_after got=%0d exp=0", bus.oINFLIGHT); end
  endtask

  task automatic test_round_robin();
    int rr_exp[4] = '{0, 1, 0, 1};
    int g;
    logic [71:0] a0, a1, sent;
    sync_clear();
    a0 = rnd72(); a1 = rnd72();
    bus.iREQ0_VALID = 1'b1; bus.iREQ0_DATA_A = a0; bus.iREQ0_DATA_B = rnd72();
    bus.iREQ1_VALID = 1'b1; bus.iREQ1_DATA_A = a1; bus.iREQ1_DATA_B = rnd72();
    for (int i = 0; i < 4; i++) begin
      #1;
      g = (bus.oREQ0_BUSY === 1'b0) ? 0 : ((bus.oREQ1_BUSY === 1'b0) ? 1 : 2);
      checks++; if (g != rr_exp[i]) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, g, rr_exp[i]); end
      sent = (g == 1) ? a1 : a0;
      tick();
      checks++; if (bus.oPIPE_VALID !== 1'b1 || bus.oPIPE_DATA_A !== sent) begin failures++; $display("FAIL rr_issue%0d got=%b/%h exp=1/%h", i, bus.oPIPE_VALID, bus.oPIPE_DATA_A, sent); end
      if (g == 1) begin a1 = rnd72(); bus.iREQ1_DATA_A = a1; end
      else begin a0 = rnd72(); bus.iREQ0_DATA_A = a0; end
    end
    bus.iREQ0_VALID = 1'b0; bus.iREQ1_VALID = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.iPIPE_RESULT_VALID = 1'b1; bus.iPIPE_RESULT_DATA = rnd72(); #1;
      checks++; if (bus.oRES0_VALID !== (rr_exp[i] == 0) || bus.oRES1_VALID !== (rr_exp[i] == 1)) begin failures++; $display("FAIL rr_route%0d got=%b%b exp_req=%0d", i, bus.oRES1_VALID, bus.oRES0_VALID, rr_exp[i]); end
      tick();
    end
    bus.iPIPE_RESULT_VALID = 1'b0;
    checks++; if (bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL rr_drain got=%0d exp=0", bus.oINFLIGHT); end
  endtask

  task automatic test_credit_limit();
    int accepted;
    sync_clear();
    accepted = 0;
    bus.iREQ0_VALID = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.iREQ0_DATA_A = rnd72(); bus.iREQ0_DATA_B = rnd72(); #1;
      if (bus.oREQ0_BUSY === 1'b0) accepted++;
      tick();
    end
    checks++; if (accepted != MAXI) begin failures++; $display("FAIL credit_accepted got=%0d exp=%0d", accepted, MAXI); end
    checks++; if (bus.oINFLIGHT !== 5'(MAXI)) begin failures++; $display("FAIL credit_inflight got=%0d exp=%0d", bus.oINFLIGHT, MAXI); end
    bus.iPIPE_RESULT_VALID = 1'b1; bus.iPIPE_RESULT_DATA = rnd72(); #1;
    checks++; if (bus.oREQ0_BUSY !== 1'b1) begin failures++; $display("FAIL credit_busy_same_cycle got=%b exp=1", bus.oREQ0_BUSY); end
    tick(); bus.iPIPE_RESULT_VALID = 1'b0; #1;
    checks++; if (bus.oREQ0_BUSY !== 1'b0) begin failures++; $display("FAIL credit_regrant got=%b exp=0", bus.oREQ0_BUSY); end
    tick(); bus.iREQ0_VALID = 1'b0;
    checks++; if (bus.oINFLIGHT !== 5'(MAXI)) begin failures++; $display("FAIL credit_refill got=%0d exp=%0d", bus.oINFLIGHT, MAXI); end
  endtask

  task automatic test_stall();
    logic [71:0] x;
    sync_clear();
    x = rnd72();
    bus.iREQ1_VALID = 1'b1; bus.iREQ1_DATA_A = x; bus.iREQ1_DATA_B = rnd72();
    tick();
    bus.iPIPE_BUSY = 1'b1; bus.iREQ0_VALID = 1'b1;
    bus.iREQ0_DATA_A = rnd72(); bus.iREQ1_DATA_A = rnd72();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.oREQ0_BUSY !== 1'b1 || bus.oREQ1_BUSY !== 1'b1) begin failures++; $display("FAIL stall_req_busy%0d got=%b%b exp=11", i, bus.oREQ1_BUSY, bus.oREQ0_BUSY); end
      tick();
      checks++; if (bus.oPIPE_VALID !== 1'b1 || bus.oPIPE_DATA_A !== x) begin failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", i, bus.oPIPE_VALID, bus.oPIPE_DATA_A, x); end
    end
    bus.iPIPE_BUSY = 1'b0; bus.iREQ0_VALID = 1'b0; bus.iREQ1_VALID = 1'b0;
    tick();
    bus.iPIPE_RESULT_VALID = 1'b1; bus.iRES1_BUSY = 1'b1; bus.iPIPE_RESULT_DATA = rnd72();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.oPIPE_RESULT_BUSY !== 1'b1 || bus.oRES1_VALID !== 1'b1) begin failures++; $display("FAIL stall_res_busy%0d got=%b/%b exp=1/1", i, bus.oPIPE_RESULT_BUSY, bus.oRES1_VALID); end
      tick();
      checks++; if (bus.oINFLIGHT !== 5'd1) begin failures++; $display("FAIL stall_no_pop%0d got=%0d exp=1", i, bus.oINFLIGHT); end
    end
    bus.iRES1_BUSY = 1'b0; #1;
    checks++; if (bus.oPIPE_RESULT_BUSY !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", bus.oPIPE_RESULT_BUSY); end
    tick(); bus.iPIPE_RESULT_VALID = 1'b0;
    checks++; if (bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL stall_pop got=%0d exp=0", bus.oINFLIGHT); end
  endtask

  task automatic test_push_pop_wrap();
    bit pick;
    sync_clear();
    bus.iREQ0_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.iREQ0_DATA_A = rnd72(); tick(); end
    for (int i = 0; i < 24; i++) begin
      pick = 1'($urandom_range(1, 0));
      bus.iREQ0_VALID = !pick; bus.iREQ1_VALID = pick;
      bus.iREQ0_DATA_A = rnd72(); bus.iREQ1_DATA_A = rnd72();
      bus.iPIPE_RESULT_VALID = 1'b1; bus.iPIPE_RESULT_DATA = rnd72(); #1;
      model_eval();
      checks++; if ((pick ? bus.oREQ1_BUSY : bus.oREQ0_BUSY) !== 1'b0) begin failures++; $display("FAIL pp_grant%0d req=%0d got_busy=1 exp=0", i, pick); end
      checks++; if (bus.oRES0_VALID !== e_r0 || bus.oRES1_VALID !== e_r1) begin failures++; $display("FAIL pp_route%0d got=%b%b exp=%b%b", i, bus.oRES1_VALID, bus.oRES0_VALID, e_r1, e_r0); end
      tick();
      checks++; if (bus.oINFLIGHT !== 5'd3) begin failures++; $display("FAIL pp_count%0d got=%0d exp=3", i, bus.oINFLIGHT); end
    end
    // Free-running traffic with random stalls on every side
    for (int i = 0; i < 80; i++) begin
      bus.iREQ0_VALID = 1'($urandom_range(1, 0)); bus.iREQ0_DATA_A = rnd72(); bus.iREQ0_DATA_B = rnd72();
      bus.iREQ1_VALID = 1'($urandom_range(1, 0)); bus.iREQ1_DATA_A = rnd72(); bus.iREQ1_DATA_B = rnd72();
      bus.iPIPE_BUSY = ($urandom_range(3, 0) == 0);
      bus.iPIPE_RESULT_VALID = 1'($urandom_range(1, 0)); bus.iPIPE_RESULT_DATA = rnd72();
      bus.iRES0_BUSY = ($urandom_range(3, 0) == 0); bus.iRES1_BUSY = ($urandom_range(3, 0) == 0);
      #1; model_eval();
      checks++; if (bus.oREQ0_BUSY !== !e_g0 || bus.oREQ1_BUSY !== !e_g1) begin failures++; $display("FAIL rnd_busy%0d got=%b%b exp=%b%b", i, bus.oREQ1_BUSY, bus.oREQ0_BUSY, !e_g1, !e_g0); end
      checks++; if (bus.oRES0_VALID !== e_r0 || bus.oRES1_VALID !== e_r1 || bus.oPIPE_RESULT_BUSY !== e_rb) begin failures++; $display("FAIL rnd_route%0d got=%b%b/%b exp=%b%b/%b", i, bus.oRES1_VALID, bus.oRES0_VALID, bus.oPIPE_RESULT_BUSY, e_r1, e_r0, e_rb); end
      checks++; if (bus.oRES0_DATA !== bus.iPIPE_RESULT_DATA || bus.oRES1_DATA !== bus.iPIPE_RESULT_DATA) begin failures++; $display("FAIL rnd_res_data%0d got=%h/%h", i, bus.oRES0_DATA, bus.oRES1_DATA); end
      tick();
      checks++; if (bus.oPIPE_VALID !== m_sv || (m_sv && (bus.oPIPE_DATA_A !== m_sa || bus.oPIPE_DATA_B !== m_sb))) begin failures++; $display("FAIL rnd_stage%0d got=%b/%h exp=%b/%h", i, bus.oPIPE_VALID, bus.oPIPE_DATA_A, m_sv, m_sa); end
      checks++; if (bus.oINFLIGHT !== 5'(m_tags.size()) || bus.oERR_ORPHAN !== m_orph) begin failures++; $display("FAIL rnd_count%0d got=%0d/%b exp=%0d/%b", i, bus.oINFLIGHT, bus.oERR_ORPHAN, m_tags.size(), m_orph); end
    end
    idle();
    for (int i = 0; i < 20 && m_tags.size() != 0; i++) begin
      bus.iPIPE_RESULT_VALID = 1'b1; tick();
    end
    bus.iPIPE_RESULT_VALID = 1'b0;
    checks++; if (bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", bus.oINFLIGHT); end
  endtask

  task automatic test_orphan_reset();
    sync_clear();
    bus.iPIPE_RESULT_VALID = 1'b1; bus.iPIPE_RESULT_DATA = rnd72(); #1;
    checks++; if (bus.oRES0_VALID !== 1'b0 || bus.oRES1_VALID !== 1'b0) begin failures++; $display("FAIL orphan_route got=%b%b exp=00", bus.oRES1_VALID, bus.oRES0_VALID); end
    tick(); bus.iPIPE_RESULT_VALID = 1'b0;
    checks++; if (bus.oERR_ORPHAN !== 1'b1) begin failures++; $display("FAIL orphan_set got=%b exp=1", bus.oERR_ORPHAN); end
    tick();
    checks++; if (bus.oERR_ORPHAN !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", bus.oERR_ORPHAN); end
    bus.iREQ1_VALID = 1'b1; tick(); bus.iREQ1_VALID = 1'b0;
    srst = 1'b1; tick(); srst = 1'b0;
    checks++; if (bus.oERR_ORPHAN !== 1'b0 || bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL srst_clear got=%b/%0d exp=0/0", bus.oERR_ORPHAN, bus.oINFLIGHT); end
    bus.iREQ0_VALID = 1'b1; bus.iREQ0_DATA_A = rnd72(); tick(); bus.iREQ0_VALID = 1'b0;
    checks++; if (bus.oPIPE_VALID !== 1'b1) begin failures++; $display("FAIL async_pre got=%b exp=1", bus.oPIPE_VALID); end
    #2; rst_n = 1'b0; #1;
    checks++; if (bus.oPIPE_VALID !== 1'b0 || bus.oINFLIGHT !== 5'd0) begin failures++; $display("FAIL async_reset got=%b/%0d exp=0/0", bus.oPIPE_VALID, bus.oINFLIGHT); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_round_robin();
    test_credit_limit();
    test_stall();
    test_push_pop_wrap();
    test_orphan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
